// File: rtl/bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_pkg                                                         |
// | Purpose  : Shared widths and FSM state encoding for the 3-digit BCD to     |
// |            binary converter.                                               |
// | Contents : DIGITS, BIN_W, BCD_W, state_t (IDLE, CONV, DONE)                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package bcd_pkg;

  localparam int DIGITS = 3;   // BCD digits per operand
  localparam int BIN_W  = 10;  // enough for 0..999
  localparam int BCD_W  = 4;   // one BCD digit

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_mac10.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_mac10                                                       |
// | Purpose  : Combinational multiply-by-10-and-add step, result = acc*10+digit|
// | Ports    : acc    [BIN_W-1:0] in  - running binary accumulator             |
// |            digit  [BCD_W-1:0] in  - next BCD digit                         |
// |            result [BIN_W-1:0] out - acc*10 + digit, truncated to BIN_W     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bcd_mac10
  import bcd_pkg::*;
(
  input  logic [BIN_W-1:0] acc,
  input  logic [BCD_W-1:0] digit,
  output logic [BIN_W-1:0] result
);

  localparam int WIDE_W = BIN_W + 4;

  // Four guard bits keep the full sum (acc*10 fits in BIN_W+4 bits) before
  // truncation, so valid inputs up to 999 never wrap.
  logic [WIDE_W-1:0] acc_wide;
  logic [WIDE_W-1:0] sum_wide;
  logic              unused_hi;

  assign acc_wide  = {4'b0000, acc};
  assign sum_wide  = (acc_wide << 3) + (acc_wide << 1) + {{BIN_W{1'b0}}, digit};
  assign result    = sum_wide[BIN_W-1:0];

  // Upper bits are only non-zero when an invalid digit inflated the
  // accumulator; that result is discarded by the error path anyway.
  assign unused_hi = &{1'b0, sum_wide[WIDE_W-1:BIN_W]};

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_to_bin                                                      |
// | Purpose  : Sequential 3-digit BCD to binary converter with valid/ready     |
// |            handshakes on both sides. One digit is folded in per cycle.     |
// | Ports    : clk, rst_b (async, active-low)                                  |
// |            in_valid/in_ready    - operand handshake                        |
// |            cif_s/cif_z/cif_u    - hundreds/tens/units BCD digits           |
// |            out_valid/out_ready  - result handshake                         |
// |            bin [9:0]            - binary result (0 when err)               |
// |            err                  - some captured digit was > 9              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BCD_W-1:0] cif_s,
  input  logic [BCD_W-1:0] cif_z,
  input  logic [BCD_W-1:0] cif_u,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] bin,
  output logic             err
);

  localparam int             IDX_W    = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [BIN_W-1:0] acc;
  logic [BIN_W-1:0] mac_out;
  logic [BCD_W-1:0] dig_s;
  logic [BCD_W-1:0] dig_z;
  logic [BCD_W-1:0] dig_u;
  logic [BCD_W-1:0] cur_digit;
  logic             err_flag;

  // Decoded from state alone so the producer sees no combinational path
  // from in_valid back to in_ready.
  assign in_ready = (state == IDLE);

  // Most significant digit first: acc = ((s*10)+z)*10+u.
  always_comb begin
    cur_digit = dig_u;
    case (idx)
      2'd0:    cur_digit = dig_s;
      2'd1:    cur_digit = dig_z;
      default: cur_digit = dig_u;
    endcase
  end

  bcd_mac10 u_mac (
    .acc    (acc),
    .digit  (cur_digit),
    .result (mac_out)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      dig_s     <= '0;
      dig_z     <= '0;
      dig_u     <= '0;
      err_flag  <= 1'b0;
      out_valid <= 1'b0;
      bin       <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dig_s    <= cif_s;
            dig_z    <= cif_z;
            dig_u    <= cif_u;
            acc      <= '0;
            idx      <= '0;
            err_flag <= (cif_s > 4'd9) | (cif_z > 4'd9) | (cif_u > 4'd9);
            state    <= CONV;
          end
        end
        CONV: begin
          // Invalid digits still run all steps so latency is data-independent.
          acc <= mac_out;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state     <= DONE;
            out_valid <= 1'b1;
            bin       <= err_flag ? '0 : mac_out;
            err       <= err_flag;
          end
        end
        DONE: begin
          // bin/err are left untouched so they persist after the handshake.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bcd_to_bin                                                   |
// | Purpose  : Directed and random self-checking bench for bcd_to_bin.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_bcd_to_bin;

  logic       clk;
  logic       rst_b;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cif_s;
  logic [3:0] cif_z;
  logic [3:0] cif_u;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] bin;
  logic       err;

  int passed;
  int total;

  bcd_to_bin #(.DIGITS(3)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cif_s     (cif_s),
    .cif_z     (cif_z),
    .cif_u     (cif_u),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin       (bin),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operand with out_ready=1, scrambles the digit inputs after the
  // accept edge, and reports what it observed. Comparisons live in callers.
  task automatic run_op(input logic [3:0] s, input logic [3:0] z, input logic [3:0] u,
                        output int lat, output logic [9:0] b, output logic e,
                        output logic ir_after, output logic ov_after);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cif_s = s; cif_z = z; cif_u = u;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cif_s = 4'($urandom); cif_z = 4'($urandom); cif_u = 4'($urandom);
    ir_after = in_ready;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    b = bin;
    e = err;
    @(posedge clk); #1;
    ov_after = out_valid;
  endtask

  task automatic test_reset;
    rst_b = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cif_s = 4'd0; cif_z = 4'd0; cif_u = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b1)  $display("FAIL reset_in_ready: got %b expected 1", in_ready);  else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (bin !== 10'd0)      $display("FAIL reset_bin: got %0d expected 0", bin);           else passed++;
    total++; if (err !== 1'b0)       $display("FAIL reset_err: got %b expected 0", err);            else passed++;
    rst_b = 1'b1;
  endtask

  task automatic test_basic;
    int lat; logic [9:0] b; logic e, ir, ov;
    run_op(4'd4, 4'd5, 4'd6, lat, b, e, ir, ov);
    total++; if (ir !== 1'b0)   $display("FAIL basic_in_ready_low: got %b expected 0", ir);    else passed++;
    total++; if (lat != 4)      $display("FAIL basic_latency: got %0d expected 4", lat);       else passed++;
    total++; if (b !== 10'd456) $display("FAIL basic_bin: got %0d expected 456", b);          else passed++;
    total++; if (e !== 1'b0)    $display("FAIL basic_err: got %b expected 0", e);             else passed++;
    total++; if (ov !== 1'b0)   $display("FAIL basic_out_valid_fall: got %b expected 0", ov); else passed++;
    total++; if (bin !== 10'd456) $display("FAIL basic_bin_hold: got %0d expected 456", bin); else passed++;
  endtask

  task automatic test_boundaries;
    int lat; logic [9:0] b; logic e, ir, ov;
    run_op(4'd0, 4'd0, 4'd0, lat, b, e, ir, ov);
    total++; if (b !== 10'd0) $display("FAIL bound_000_bin: got %0d expected 0", b); else passed++;
    total++; if (e !== 1'b0)  $display("FAIL bound_000_err: got %b expected 0", e);  else passed++;
    run_op(4'd9, 4'd9, 4'd9, lat, b, e, ir, ov);
    total++; if (b !== 10'd999) $display("FAIL bound_999_bin: got %0d expected 999", b); else passed++;
    total++; if (e !== 1'b0)    $display("FAIL bound_999_err: got %b expected 0", e);    else passed++;
    total++; if (lat != 4)      $display("FAIL bound_999_latency: got %0d expected 4", lat); else passed++;
  endtask

  task automatic test_invalid_digit;
    int lat; logic [9:0] b; logic e, ir, ov;
    run_op(4'd1, 4'd10, 4'd3, lat, b, e, ir, ov);
    total++; if (e !== 1'b1)  $display("FAIL invalid_err: got %b expected 1", e);          else passed++;
    total++; if (b !== 10'd0) $display("FAIL invalid_bin: got %0d expected 0", b);         else passed++;
    total++; if (lat != 4)    $display("FAIL invalid_latency: got %0d expected 4", lat);   else passed++;
    run_op(4'd15, 4'd0, 4'd0, lat, b, e, ir, ov);
    total++; if (e !== 1'b1)  $display("FAIL invalid_s_err: got %b expected 1", e);        else passed++;
  endtask

  task automatic test_backpressure;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0;
    cif_s = 4'd0; cif_z = 4'd7; cif_u = 4'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat != 4) $display("FAIL bp_latency: got %0d expected 4", lat); else passed++;
    // A competing operand offered while the result is stalled must be dropped.
    in_valid = 1'b1; cif_s = 4'd9; cif_z = 4'd9; cif_u = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); else passed++;
      total++; if (bin !== 10'd75)     $display("FAIL bp_bin[%0d]: got %0d expected 75", i, bin);          else passed++;
      total++; if (in_ready !== 1'b0)  $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready);  else passed++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1)  $display("FAIL bp_release_in_ready: got %b expected 1", in_ready);   else passed++;
    total++; if (bin !== 10'd75)     $display("FAIL bp_release_bin_hold: got %0d expected 75", bin);      else passed++;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1)  $display("FAIL bp_not_queued: got %b expected 1", in_ready);        else passed++;
  endtask

  task automatic test_reset_mid;
    int lat; logic [9:0] b; logic e, ir, ov;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    cif_s = 4'd7; cif_z = 4'd8; cif_u = 4'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_b = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1)  $display("FAIL midrst_in_ready: got %b expected 1", in_ready);   else passed++;
    total++; if (bin !== 10'd0)      $display("FAIL midrst_bin: got %0d expected 0", bin);            else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_hold_out_valid: got %b expected 0", out_valid); else passed++;
    rst_b = 1'b1;
    run_op(4'd1, 4'd2, 4'd3, lat, b, e, ir, ov);
    total++; if (b !== 10'd123) $display("FAIL midrst_next_bin: got %0d expected 123", b);     else passed++;
    total++; if (lat != 4)      $display("FAIL midrst_next_latency: got %0d expected 4", lat); else passed++;
  endtask

  task automatic test_random;
    int lat; logic [9:0] b; logic e, ir, ov;
    logic [3:0] s, z, u;
    int exp_v;
    for (int n = 0; n < 200; n++) begin
      s = 4'($urandom_range(0, 9));
      z = 4'($urandom_range(0, 9));
      u = 4'($urandom_range(0, 9));
      exp_v = 100 * int'(s) + 10 * int'(z) + int'(u);
      run_op(s, z, u, lat, b, e, ir, ov);
      total++; if (int'(b) != exp_v) $display("FAIL rand_bin[%0d] %0d%0d%0d: got %0d expected %0d", n, s, z, u, b, exp_v); else passed++;
      total++; if (lat != 4)         $display("FAIL rand_latency[%0d]: got %0d expected 4", n, lat); else passed++;
      total++; if (e !== 1'b0)       $display("FAIL rand_err[%0d]: got %b expected 0", n, e);        else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_invalid_digit();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
